lsu_port: RTL and testbench

LSU_PORT -- requirements
Module: lsu_port

---
 rtl/lsu_port_if.sv | 29 ++
 rtl/lsu_port.sv | 76 +++++++
 tb/tb_lsu_port.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/lsu_port_if.sv
// lsu_port_if: request/response handshake and data-bus signals of the load/store port
//   master: pipeline side (drives req_*, mem_rdata); slave: lsu_port (drives req_ready, resp_*, mem_*)
interface lsu_port_if #(parameter int WIDTH = 32);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [2:0]       req_funct3;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_rdata;
    logic             resp_err;
    logic             mem_read;
    logic             mem_write;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [3:0]       mem_byteen;
    logic [WIDTH-1:0] mem_rdata;
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_read, mem_write, mem_addr, mem_wdata, mem_byteen
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_read, mem_write, mem_addr, mem_wdata, mem_byteen
    );
endinterface

// File: rtl/lsu_port.sv
// lsu_port: RV32I load/store unit splitting misaligned accesses into two word-bus cycles
//   clk, rst : clock, synchronous active-high reset
//   bus      : lsu_port_if.slave (request handshake, response, word-aligned data bus)
module lsu_port #(parameter int WIDTH = 32) (
    input logic     clk,
    input logic     rst,
    lsu_port_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;
    state_t             state, state_n;
    logic               we_q, err_q, accept, req_bad, split, acc, hi_phase, done;
    logic [2:0]         f3_q;
    logic [WIDTH-1:0]   addr_q, wdata_q, lo_q, rd_sh, rd_ext;
    logic [3:0]         size_mask;
    logic [7:0]         mask;
    logic [4:0]         sh;
    logic [2*WIDTH-1:0] data, rd_pair;
    assign accept  = bus.req_valid && state == IDLE;
    assign req_bad = bus.req_we ? !(bus.req_funct3 inside {3'd0, 3'd1, 3'd2})
                                : !(bus.req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                err_q   <= req_bad;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (state == ACC1) lo_q <= bus.mem_rdata;
        end
    end
    always_ff @(posedge clk) state <= rst ? IDLE : state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? (req_bad ? DONE : ACC0) : IDLE;
            ACC0:    state_n = split ? ACC1 : DONE;
            ACC1:    state_n = DONE;
            default: state_n = IDLE;
        endcase
    end
    // Lane alignment: mask/data span two words so a misaligned access spills into the next one.
    assign size_mask = f3_q[1:0] == 2'b00 ? 4'b0001 : f3_q[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
    assign mask      = {4'b0000, size_mask} << addr_q[1:0];
    assign sh        = {addr_q[1:0], 3'b000};
    assign data      = {{WIDTH{1'b0}}, wdata_q} << sh;
    assign split     = |mask[7:4];
    // In DONE the bus carries the last word read: the high word if split, otherwise the only word.
    assign rd_pair   = split ? {bus.mem_rdata, lo_q} : {{WIDTH{1'b0}}, bus.mem_rdata};
    assign rd_sh     = WIDTH'(rd_pair >> sh);
    assign rd_ext    = f3_q[1:0] == 2'b00 ? {{24{!f3_q[2] & rd_sh[7]}}, rd_sh[7:0]}
                     : f3_q[1:0] == 2'b01 ? {{16{!f3_q[2] & rd_sh[15]}}, rd_sh[15:0]} : rd_sh;
    always_comb begin
        acc            = state == ACC0 || state == ACC1;
        hi_phase       = state == ACC1;
        done           = state == DONE;
        bus.req_ready  = state == IDLE;
        bus.mem_read   = acc && !we_q;
        bus.mem_write  = acc && we_q;
        bus.mem_addr   = !acc ? '0 : hi_phase ? {addr_q[WIDTH-1:2] + (WIDTH-2)'(1), 2'b00}
                                              : {addr_q[WIDTH-1:2], 2'b00};
        bus.mem_byteen = !acc ? 4'b0000 : hi_phase ? mask[7:4] : mask[3:0];
        bus.mem_wdata  = !acc ? '0 : hi_phase ? data[2*WIDTH-1:WIDTH] : data[WIDTH-1:0];
        bus.resp_valid = done;
        bus.resp_err   = done && err_q;
        bus.resp_rdata = done && !we_q && !err_q ? rd_ext : '0;
    end
endmodule

// File: tb/tb_lsu_port.sv
// tb_lsu_port: directed self-checking bench for lsu_port
module tb_lsu_port;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs = 0;
    int   checks = 0;
    lsu_port_if #(.WIDTH(32)) bus ();
    lsu_port #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        step();
        bus.req_valid  = 1'b0;
    endtask
    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_rv"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_err"}, 32'(bus.resp_err), 32'd0);
        chk({tag, "_rdata"}, bus.resp_rdata, 32'd0);
        chk({tag, "_strobes"}, {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        chk({tag, "_maddr"}, bus.mem_addr, 32'd0);
        chk({tag, "_be"}, 32'(bus.mem_byteen), 32'd0);
        chk({tag, "_wdata"}, bus.mem_wdata, 32'd0);
    endtask
    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.mem_rdata  = 32'd0;
        step();
        step();
        chk_idle("reset");
        rst = 1'b0;
        // lw @0x100, non-split; request inputs wiggle while busy and must be ignored
        issue(1'b0, 3'b010, 32'h100, 32'd0);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0F00;
        #1;
        chk("lw_acc0_ready", 32'(bus.req_ready), 32'd0);
        chk("lw_acc0_read", {30'd0, bus.mem_read, bus.mem_write}, 32'd2);
        chk("lw_acc0_addr", bus.mem_addr, 32'h100);
        chk("lw_acc0_be", 32'(bus.mem_byteen), 32'hF);
        chk("lw_acc0_rv", 32'(bus.resp_valid), 32'd0);
        step();
        bus.req_valid = 1'b0;
        bus.mem_rdata = 32'h8899_AABB;
        #1;
        chk("lw_done_rv", 32'(bus.resp_valid), 32'd1);
        chk("lw_done_rdata", bus.resp_rdata, 32'h8899_AABB);
        chk("lw_done_err", 32'(bus.resp_err), 32'd0);
        chk("lw_done_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        step();
        chk_idle("lw_after");
        // lb / lbu @0x103
        issue(1'b0, 3'b000, 32'h103, 32'd0);
        chk("lb_be", 32'(bus.mem_byteen), 32'h8);
        chk("lb_addr", bus.mem_addr, 32'h100);
        step();
        bus.mem_rdata = 32'h80FF_FFFF;
        #1;
        chk("lb_rdata", bus.resp_rdata, 32'hFFFF_FF80);
        step();
        issue(1'b0, 3'b100, 32'h103, 32'd0);
        step();
        #1;
        chk("lbu_rdata", bus.resp_rdata, 32'h0000_0080);
        step();
        // lhu / lh @0x101, non-split half inside one word
        issue(1'b0, 3'b101, 32'h101, 32'd0);
        chk("lhu_be", 32'(bus.mem_byteen), 32'h6);
        step();
        bus.mem_rdata = 32'h00AB_CD00;
        #1;
        chk("lhu_rdata", bus.resp_rdata, 32'h0000_ABCD);
        step();
        issue(1'b0, 3'b001, 32'h101, 32'd0);
        step();
        chk("lh_rdata", bus.resp_rdata, 32'hFFFF_ABCD);
        step();
        // sw 0xDDCCBBAA @0x201, split
        issue(1'b1, 3'b010, 32'h201, 32'hDDCC_BBAA);
        chk("sw_acc0_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd1);
        chk("sw_acc0_addr", bus.mem_addr, 32'h200);
        chk("sw_acc0_be", 32'(bus.mem_byteen), 32'hE);
        chk("sw_acc0_wdata", bus.mem_wdata, 32'hCCBB_AA00);
        step();
        chk("sw_acc1_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd1);
        chk("sw_acc1_addr", bus.mem_addr, 32'h204);
        chk("sw_acc1_be", 32'(bus.mem_byteen), 32'h1);
        chk("sw_acc1_wdata", bus.mem_wdata, 32'h0000_00DD);
        chk("sw_acc1_rv", 32'(bus.resp_valid), 32'd0);
        step();
        chk("sw_done_rv", 32'(bus.resp_valid), 32'd1);
        chk("sw_done_rdata", bus.resp_rdata, 32'd0);
        chk("sw_done_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        step();
        // sh 0x1234 @0x102, non-split store
        issue(1'b1, 3'b001, 32'h102, 32'hFFFF_1234);
        chk("sh_be", 32'(bus.mem_byteen), 32'hC);
        chk("sh_wdata", bus.mem_wdata, 32'h1234_0000);
        step();
        chk("sh_done_rv", 32'(bus.resp_valid), 32'd1);
        step();
        // lh @0xFFFFFFFF, split with address wrap
        issue(1'b0, 3'b001, 32'hFFFF_FFFF, 32'd0);
        chk("lhw_acc0_addr", bus.mem_addr, 32'hFFFF_FFFC);
        chk("lhw_acc0_be", 32'(bus.mem_byteen), 32'h8);
        step();
        bus.mem_rdata = 32'hAB00_0000;
        chk("lhw_acc1_addr", bus.mem_addr, 32'h0000_0000);
        chk("lhw_acc1_be", 32'(bus.mem_byteen), 32'h1);
        chk("lhw_acc1_read", {30'd0, bus.mem_read, bus.mem_write}, 32'd2);
        step();
        bus.mem_rdata = 32'h0000_00CD;
        #1;
        chk("lhw_done_rv", 32'(bus.resp_valid), 32'd1);
        chk("lhw_done_rdata", bus.resp_rdata, 32'hFFFF_CDAB);
        step();
        // illegal load funct3=011
        issue(1'b0, 3'b011, 32'h100, 32'd0);
        chk("ill_rv", 32'(bus.resp_valid), 32'd1);
        chk("ill_err", 32'(bus.resp_err), 32'd1);
        chk("ill_rdata", bus.resp_rdata, 32'd0);
        chk("ill_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        step();
        chk_idle("ill_after");
        // illegal store funct3=100
        issue(1'b1, 3'b100, 32'h100, 32'd0);
        chk("ills_err", 32'(bus.resp_err), 32'd1);
        chk("ills_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        step();
        // reset during ACC1 of a split store
        issue(1'b1, 3'b010, 32'h201, 32'hDDCC_BBAA);
        step();
        chk("rst_acc1_write", 32'(bus.mem_write), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("rst_mid");
        step();
        chk_idle("rst_after");
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
